// File: rtl/music_score_player.sv
// Score sequencer and square-wave tone generator for a combinational ROM of
// {high, med, low} nibble words; one fixed-length note per ROM address.
module music_score_player #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned NOTE_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 2_500_000,
  parameter int unsigned ROM_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned SONG_LEN   = 96
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ROM_WIDTH-1:0]  rom_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  buzzer,
  output logic                  playing,
  output logic                  done
);

  localparam int unsigned ACTIVE_TICKS = NOTE_TICKS - GAP_TICKS;
  localparam int unsigned HP_MAX       = CLK_FREQ / 524;
  localparam int unsigned TICK_W       = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam int unsigned TONE_W       = $clog2(HP_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SONG_LEN - 1);

  // Half-periods CLK_FREQ / (2*f), ordered low do..ti, med do..ti, high do..ti
  localparam int unsigned HP_TABLE [21] = '{
    CLK_FREQ / 524,  CLK_FREQ / 588,  CLK_FREQ / 660,  CLK_FREQ / 698,
    CLK_FREQ / 784,  CLK_FREQ / 880,  CLK_FREQ / 988,
    CLK_FREQ / 1046, CLK_FREQ / 1174, CLK_FREQ / 1318, CLK_FREQ / 1396,
    CLK_FREQ / 1568, CLK_FREQ / 1760, CLK_FREQ / 1976,
    CLK_FREQ / 2094, CLK_FREQ / 2350, CLK_FREQ / 2638, CLK_FREQ / 2794,
    CLK_FREQ / 3136, CLK_FREQ / 3520, CLK_FREQ / 3952
  };

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t               state;
  logic [ROM_WIDTH-1:0] note;
  logic [TICK_W-1:0]    tick;
  logic [TONE_W-1:0]    tone_cnt;

  logic [1:0]           octave;
  logic [3:0]           sel_nib;
  logic                 tone_on;
  logic [4:0]           hp_idx;
  logic [TONE_W-1:0]    hp_last;

  // Priority decode high > med > low; a selected nibble of 8..F is a rest
  always_comb begin
    octave  = 2'd0;
    sel_nib = note[3:0];
    if (note[11:8] != 4'd0) begin
      octave  = 2'd2;
      sel_nib = note[11:8];
    end else if (note[7:4] != 4'd0) begin
      octave  = 2'd1;
      sel_nib = note[7:4];
    end
    tone_on = (sel_nib != 4'd0) && !sel_nib[3];
    hp_idx  = tone_on ? (5'(octave) * 5'd7 + 5'(sel_nib[2:0]) - 5'd1) : 5'd0;
    hp_last = TONE_W'(HP_TABLE[hp_idx]) - TONE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      state    <= IDLE;
      rom_addr <= '0;
      buzzer   <= 1'b0;
      playing  <= 1'b0;
      done     <= 1'b0;
      tick     <= '0;
      tone_cnt <= '0;
      note     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            rom_addr <= '0;
            playing  <= 1'b1;
          end
        end
        LOAD: begin
          note     <= rom_data;
          tick     <= '0;
          tone_cnt <= '0;
          buzzer   <= 1'b0;
          state    <= PLAY;
        end
        PLAY: begin
          if (tick == TICK_W'(NOTE_TICKS - 1)) begin
            tick     <= '0;
            tone_cnt <= '0;
            buzzer   <= 1'b0;
            state    <= LOAD;
            if (rom_addr < LAST_ADDR) begin
              rom_addr <= rom_addr + ADDR_WIDTH'(1);
            end else begin
              done     <= 1'b1;
              rom_addr <= '0;
              if (!loop_en) begin
                state   <= IDLE;
                playing <= 1'b0;
              end
            end
          end else begin
            tick <= tick + TICK_W'(1);
            // Silence is applied one tick early so the registered pin is low for the whole gap
            if (tick >= TICK_W'(ACTIVE_TICKS - 1) || !tone_on) begin
              buzzer   <= 1'b0;
              tone_cnt <= '0;
            end else if (tone_cnt == hp_last) begin
              tone_cnt <= '0;
              buzzer   <= ~buzzer;
            end else begin
              tone_cnt <= tone_cnt + TONE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_score_player.sv
// Bench for music_score_player: table-driven note checks, directed corner
// sequences and a random run compared against a timeline model.
module tb_music_score_player;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned NOTE_TICKS = 3000;
  localparam int unsigned GAP_TICKS  = 300;
  localparam int unsigned SONG_LEN   = 4;
  localparam int ACTIVE    = int'(NOTE_TICKS - GAP_TICKS);
  localparam int NOTE_CYC  = int'(NOTE_TICKS) + 1;
  localparam int SONG_CYC  = int'(SONG_LEN) * NOTE_CYC;
  localparam int FREQ [3][7] = '{
    '{262, 294, 330, 349, 392, 440, 494},
    '{523, 587, 659, 698, 784, 880, 988},
    '{1047, 1175, 1319, 1397, 1568, 1760, 1976}
  };

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic [11:0] rom_data;
  logic [6:0]  rom_addr;
  logic        buzzer, playing, done;
  logic [11:0] rom [SONG_LEN];

  int n_checks = 0;
  int n_fail   = 0;

  music_score_player #(
    .CLK_FREQ(CLK_FREQ), .NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(GAP_TICKS),
    .ROM_WIDTH(12), .ADDR_WIDTH(7), .SONG_LEN(SONG_LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_data(rom_data), .rom_addr(rom_addr), .buzzer(buzzer),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  assign rom_data = (rom_addr < 7'(SONG_LEN)) ? rom[rom_addr[1:0]] : 12'h000;

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Reference: half-period from the frequency table, first nonzero nibble wins
  function automatic int model_hp(input logic [11:0] w);
    int oct = -1;
    int sel = 0;
    for (int o = 2; o >= 0; o--) begin
      if (oct < 0 && w[o*4 +: 4] != 4'd0) begin
        oct = o;
        sel = int'(w[o*4 +: 4]);
      end
    end
    if (oct < 0 || sel > 7) return 0;
    return int'(CLK_FREQ) / (2 * FREQ[oct][sel-1]);
  endfunction

  function automatic logic model_tone(input logic [11:0] w, input int k);
    int hp = model_hp(w);
    if (hp == 0 || k >= ACTIVE) return 1'b0;
    return ((k / hp) % 2) == 1;
  endfunction

  // Timeline model: everything follows from the cycle the start was accepted
  int cyc = 0;
  bit m_active = 0;
  bit m_loop = 0;
  int m_t0 = 0;
  bit mon_en = 0;
  int bad_cycles = 0;

  function automatic bit model_idle(input int c);
    return !m_active || (!m_loop && (c - m_t0 - 1) >= SONG_CYC);
  endfunction

  always @(posedge clk) begin
    if (rst || stop) begin
      m_active <= 1'b0;
    end else if (start && model_idle(cyc)) begin
      m_active <= 1'b1;
      m_t0     <= cyc;
      m_loop   <= loop_en;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int e, n, ph, a;
    logic [6:0] ea;
    logic eb, ep, ed;
    ea = '0; eb = 1'b0; ep = 1'b0; ed = 1'b0;
    if (mon_en) begin
      if (m_active) begin
        e = cyc - m_t0 - 1;
        if (!m_loop && e >= SONG_CYC) begin
          ed = (e == SONG_CYC);
        end else begin
          n  = e / NOTE_CYC;
          ph = e % NOTE_CYC;
          a  = n % int'(SONG_LEN);
          ea = 7'(a);
          ep = 1'b1;
          ed = (ph == 0) && (n > 0) && (a == 0);
          eb = (ph == 0) ? 1'b0 : model_tone(rom[a], ph - 1);
        end
      end
      if (rom_addr !== ea || buzzer !== eb || playing !== ep || done !== ed)
        bad_cycles++;
    end
  end

  task automatic check_model(input string name);
    check({"model_", name}, bad_cycles, 0);
    bad_cycles = 0;
  endtask

  typedef struct {
    logic [11:0] word;
    int          hp;
  } vec_t;
  vec_t tbl [8];

  // Plays tbl[base..base+3] from start; checks addr, tone timing and gap per note
  task automatic play_song(input int base, input bit lp);
    int first, changes, gap_hi, hp;
    logic prev;
    for (int i = 0; i < int'(SONG_LEN); i++) rom[i] = tbl[base + i].word;
    loop_en = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(SONG_LEN); i++) begin
      check($sformatf("addr_note%0d", base + i), int'(rom_addr), i);
      check($sformatf("playing_load%0d", base + i), int'(playing), 1);
      hp = tbl[base + i].hp;
      first = -1; changes = 0; gap_hi = 0; prev = 1'b0;
      for (int k = 0; k < int'(NOTE_TICKS); k++) begin
        @(negedge clk);
        if (k > 0 && k < ACTIVE && buzzer != prev) changes++;
        if (first < 0 && buzzer) first = k;
        if (k >= ACTIVE && buzzer) gap_hi++;
        prev = buzzer;
      end
      check($sformatf("first_toggle%0d", base + i), first, (hp == 0) ? -1 : hp);
      check($sformatf("toggles%0d", base + i), changes, (hp == 0) ? 0 : (ACTIVE - 1) / hp);
      check($sformatf("gap_high%0d", base + i), gap_hi, 0);
      @(negedge clk);
    end
    check($sformatf("done_pulse%0d", base), int'(done), 1);
    check($sformatf("end_addr%0d", base), int'(rom_addr), 0);
    check($sformatf("end_playing%0d", base), int'(playing), int'(lp));
    @(negedge clk);
    check($sformatf("done_width%0d", base), int'(done), 0);
  endtask

  initial begin
    #(10 * 120_000);
    $display("FAIL watchdog: simulation exceeded time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{12'h001, 1908};
    tbl[1] = '{12'h050, 637};
    tbl[2] = '{12'h600, 284};
    tbl[3] = '{12'h009, 0};
    tbl[4] = '{12'h104, 477};
    tbl[5] = '{12'h000, 0};
    tbl[6] = '{12'h700, 253};
    tbl[7] = '{12'h0C1, 0};
    for (int i = 0; i < int'(SONG_LEN); i++) rom[i] = 12'h000;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_addr", int'(rom_addr), 0);
    check("reset_buzzer", int'(buzzer), 0);
    check("reset_playing", int'(playing), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // start together with stop must not leave IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    check("start_stop_playing", int'(playing), 0);
    @(negedge clk);
    check("start_stop_playing2", int'(playing), 0);
    check("start_stop_addr", int'(rom_addr), 0);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);

    play_song(0, 1'b0);
    check_model("song_once");

    // Looping song, then stop while a tone is sounding at addr 2
    play_song(4, 1'b1);
    check("loop_playing", int'(playing), 1);
    repeat (2 * NOTE_CYC + 300) @(negedge clk);
    check("pre_stop_addr", int'(rom_addr), 2);
    check("pre_stop_buzzer", int'(buzzer), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_buzzer", int'(buzzer), 0);
    check("stop_addr", int'(rom_addr), 0);
    check("stop_playing", int'(playing), 0);
    check("stop_done", int'(done), 0);
    check_model("song_loop_stop");

    // Reset mid-note, then replay from address 0
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1501) @(negedge clk);
    check("pre_rst_buzzer", int'(buzzer), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_addr", int'(rom_addr), 0);
    check("rst_buzzer", int'(buzzer), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("replay_addr0", int'(rom_addr), 0);
    check("replay_playing", int'(playing), 1);
    repeat (NOTE_CYC) @(negedge clk);
    check("replay_addr1", int'(rom_addr), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_model("rst_replay");

    // Random scores, loop setting and stray start pulses against the model
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < int'(SONG_LEN); i++) begin
        logic [11:0] w;
        w = '0;
        for (int j = 0; j < 3; j++)
          if ($urandom_range(0, 1) == 1) w[j*4 +: 4] = 4'($urandom_range(1, 15));
        rom[i] = w;
      end
      loop_en = 1'($urandom_range(0, 1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(1000, 5000)) begin
        @(negedge clk);
        start = ($urandom_range(0, 199) == 0);
      end
      start = 1'b0;
      if ($urandom_range(0, 1) == 1) stop = 1'b1; else rst = 1'b1;
      @(negedge clk);
      stop = 1'b0; rst = 1'b0;
      @(negedge clk);
      check_model($sformatf("random%0d", it));
    end

    @(negedge clk);
    #1;
    check_model("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/music_score_player.md
Name: music_score_player

Overview:
Sequencer and tone generator that reads the combinational music score ROM (12-bit {high,med,low} nibble words) one address at a time. It decodes each word into a square-wave half-period and drives the buzzer pin for a fixed note duration. A short silent gap ends each note so repeated notes stay distinct. It sits between the ROM and the board buzzer output, and is controlled by start/stop/loop signals from the top-level I/O logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz; used to derive the tone half-periods at elaboration.
NOTE_TICKS, 25_000_000, clock cycles spent in PLAY per ROM entry; must be > GAP_TICKS.
GAP_TICKS, 2_500_000, final cycles of each note forced silent (articulation).
ROM_WIDTH, 12, ROM word width {high[3:0], med[3:0], low[3:0]}.
ADDR_WIDTH, 7, ROM address width.
SONG_LEN, 96, number of ROM entries played; last address is SONG_LEN-1.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high, single clock domain
start  in  1  level/pulse; begins playback from address 0 when idle
stop  in  1  aborts playback immediately
loop_en  in  1  when 1, wrap to address 0 after the last note instead of stopping
rom_data  in  ROM_WIDTH  word for rom_addr, valid in the same cycle (combinational ROM)
rom_addr  out  ADDR_WIDTH  registered ROM address
buzzer  out  1  square-wave drive, 0 when silent
playing  out  1  1 in LOAD/PLAY
done  out  1  one-cycle pulse when the last note (SONG_LEN-1) finishes

Behaviour:
- Reset: state=IDLE, rom_addr=0, buzzer=0, playing=0, done=0, all counters=0, note register=0.
- FSM states: IDLE, LOAD, PLAY.
- IDLE: if start=1 and stop=0 -> LOAD with rom_addr=0.
- LOAD (1 cycle): latch rom_data into the note register, clear the tick and tone counters, set buzzer=0 -> PLAY.
- PLAY: tick counter runs 0..NOTE_TICKS-1.
  - Ticks 0..NOTE_TICKS-GAP_TICKS-1: tone active.
  - Remaining ticks: buzzer forced 0; tone counter held at 0.
  - At tick NOTE_TICKS-1, if rom_addr < SONG_LEN-1: rom_addr+1 -> LOAD.
  - At the last address: pulse done. If loop_en=1: rom_addr=0 -> LOAD. Otherwise: rom_addr=0 -> IDLE.
- Note timing: each entry occupies NOTE_TICKS+1 cycles (1 LOAD + NOTE_TICKS PLAY). Start sampled in cycle t: LOAD at t+1, PLAY from t+2.
- Tone decode, priority high > med > low: the first nonzero nibble selects the note. Nibble 1..7 = do..ti. Nibble 0 in all three fields, or a selected nibble of 8..F, means silent (buzzer held 0).
- Frequencies in Hz:
  - low 1..7: 262, 294, 330, 349, 392, 440, 494
  - med: 523, 587, 659, 698, 784, 880, 988
  - high: 1047, 1175, 1319, 1397, 1568, 1760, 1976
- Half-period HP = CLK_FREQ / (2*f), integer-truncated, constant at elaboration. Tone counter counts 0..HP-1. On reaching HP-1 it wraps to 0 and buzzer toggles. The first toggle occurs at PLAY tick HP-1.
- Counter widths must hold NOTE_TICKS-1 and the largest HP (low 1) without overflow.
- stop=1 in any state -> IDLE next cycle, with rom_addr=0, buzzer=0, playing=0, and no done pulse. stop has priority over start and over note advance in the same cycle.
- start while in LOAD/PLAY is ignored (no restart).
- loop_en is sampled only at the end of the last note; changing it mid-song has no other effect.
- rst mid-song behaves like reset: all outputs return to reset values next cycle.
- playing=1 exactly in LOAD and PLAY, and stays 1 across the loop wrap.

Test Plan:
- CLK_FREQ=1_000_000, NOTE_TICKS=20000, GAP_TICKS=2000, rom_data=12'h001; pulse start -> rom_addr=0, buzzer first toggles 1908 cycles after entering PLAY, toggles every 1908 cycles, and is 0 from tick 18000 to 19999.
- Same settings, rom_data=12'h050 at addr 1 and 12'h600 at addr 2 -> half-periods 637 and 284; rom_addr steps 0→1→2 every 20001 cycles.
- rom_data=12'h000 and separately 12'h009 -> buzzer stays 0 for the whole note; timing and addr advance are unchanged.
- SONG_LEN=4, loop_en=0 -> done pulses once, exactly 1 cycle, after addr 3's last tick; then IDLE, playing=0, rom_addr=0. With loop_en=1 -> done pulses, rom_addr wraps to 0, playing stays 1.
- start and stop asserted together in IDLE -> stays IDLE. stop mid-PLAY at addr 2 -> next cycle buzzer=0, rom_addr=0, playing=0, done=0.
- rst asserted mid-PLAY for 1 cycle -> all outputs at reset values next cycle; a new start replays from addr 0.
